// File: rtl/vproc_resp_pkg.sv
// Shared definitions for the VProc bus responder: FSM encoding, register
// offsets, CTRL bit positions and the default identification word.
package vproc_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [31:0] OFF_CTRL    = 32'd0;
  localparam logic [31:0] OFF_STATUS  = 32'd1;
  localparam logic [31:0] OFF_LOAD    = 32'd2;
  localparam logic [31:0] OFF_COUNT   = 32'd3;
  localparam logic [31:0] OFF_SCRATCH = 32'd4;
  localparam logic [31:0] OFF_ID      = 32'd5;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_AUTO = 2;

  localparam logic [31:0] ID_DEFAULT = 32'h5650_0001;

endpackage

// File: rtl/vproc_resp_timer.sv
// Down-counting timer: holds COUNT and PEND, and asks the top level to drop
// EN when a one-shot expiry happens.
module vproc_resp_timer
  import vproc_resp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        auto_reload,
  input  logic        load_we,
  input  logic [31:0] load_wdata,
  input  logic [31:0] reload_val,
  input  logic        pend_clr,
  output logic [31:0] count,
  output logic        pend,
  output logic        en_clr
);

  logic expire;

  assign expire = en & (count == 32'd0);
  assign en_clr = expire & ~auto_reload;

  // A LOAD write overrides any decrement or reload in the same cycle; a
  // timer set of PEND overrides a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      pend  <= 1'b0;
    end else begin
      if (load_we) begin
        count <= load_wdata;
      end else if (en) begin
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else if (auto_reload) begin
          count <= reload_val;
        end
      end
      if (expire) begin
        pend <= 1'b1;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vproc_bus_responder.sv
// Memory-mapped VProc bus target with configurable wait states, a small
// register bank and a timer interrupt.
module vproc_bus_responder
  import vproc_resp_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_BITS   = 3,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic        RD,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        WRAck,
  output logic        RDAck,
  output logic        Irq
);

  localparam int unsigned WAIT_M1   = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
  localparam logic [3:0]  WAIT_INIT = WAIT_M1[3:0];

  // Handshake: WE/RD are held by VProc until the matching one-cycle ack;
  // a request is only sampled in IDLE, so the edge leaving ACK never
  // re-accepts the still-present request.
  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             wait_cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            data_q;
  logic                   write_q;

  logic                   req;
  logic                   in_idle;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic [31:0]            cur_data;
  logic                   cur_write;
  logic [31:0]            word_off;
  logic                   wr_en;
  logic                   rd_en;
  logic [31:0]            do_d;
  logic [31:0]            rdata;

  logic [2:0]             ctrl_q;
  logic [31:0]            load_q;
  logic [31:0]            scratch_q;
  logic [31:0]            count;
  logic                   pend;
  logic                   en_clr;
  logic                   ctrl_we;
  logic                   status_we;
  logic                   load_we;
  logic                   scratch_we;
  logic                   timer_en;
  logic                   unused_addr;

  assign unused_addr = ^Addr[31:ADDR_BITS];
  assign req         = CS & (WE | RD);
  assign in_idle     = (state == ST_IDLE);

  // With zero wait states ACK is entered on the sampling edge itself, so the
  // live bus fields are used until the captured copies are valid.
  assign cur_addr  = in_idle ? Addr[ADDR_BITS-1:0] : addr_q;
  assign cur_data  = in_idle ? DI : data_q;
  assign cur_write = in_idle ? WE : write_q;
  assign word_off  = {{(32-ADDR_BITS){1'b0}}, cur_addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_idle && req) begin
        addr_q   <= Addr[ADDR_BITS-1:0];
        data_q   <= DI;
        write_q  <= WE;
        wait_cnt <= WAIT_INIT;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req) state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    do_d  = DO;
    if (state_nxt == ST_ACK) begin
      if (cur_write) begin
        wr_en = 1'b1;
      end else begin
        rd_en = 1'b1;
        do_d  = rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WRAck <= 1'b0;
      RDAck <= 1'b0;
      DO    <= '0;
      Irq   <= 1'b0;
    end else begin
      WRAck <= wr_en;
      RDAck <= rd_en;
      DO    <= do_d;
      Irq   <= pend & ctrl_q[CTRL_IE];
    end
  end

  assign ctrl_we    = wr_en & (word_off == OFF_CTRL);
  assign status_we  = wr_en & (word_off == OFF_STATUS);
  assign load_we    = wr_en & (word_off == OFF_LOAD);
  assign scratch_we = wr_en & (word_off == OFF_SCRATCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      scratch_q <= '0;
    end else begin
      if (ctrl_we) begin
        ctrl_q <= cur_data[2:0];
      end else if (en_clr) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end
      if (load_we)    load_q    <= cur_data;
      if (scratch_we) scratch_q <= cur_data;
    end
  end

  // A CTRL write that clears EN suppresses the timer in that same cycle.
  assign timer_en = ctrl_q[CTRL_EN] & ~(ctrl_we & ~cur_data[CTRL_EN]);

  vproc_resp_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .en          (timer_en),
    .auto_reload (ctrl_q[CTRL_AUTO]),
    .load_we     (load_we),
    .load_wdata  (cur_data),
    .reload_val  (load_q),
    .pend_clr    (status_we & cur_data[0]),
    .count       (count),
    .pend        (pend),
    .en_clr      (en_clr)
  );

  always_comb begin
    rdata = '0;
    case (word_off)
      OFF_CTRL:    rdata = {29'd0, ctrl_q};
      OFF_STATUS:  rdata = {31'd0, pend};
      OFF_LOAD:    rdata = load_q;
      OFF_COUNT:   rdata = count;
      OFF_SCRATCH: rdata = scratch_q;
      OFF_ID:      rdata = ID_VALUE;
      default:     rdata = '0;
    endcase
  end

endmodule
